// File: rtl/uart_baud_gen_if.sv
// Purpose : bundles the control inputs and strobe outputs of the UART baud-tick generator.
// Latency : none, wiring only.
// Backpressure: none; every strobe is a one-cycle pulse with no handshake.
// Ports   : EN, INC_LOAD, INC_IN, RX_RESYNC (controller -> generator);
//           TICK_OVS, TICK_TX, RX_SAMPLE, RX_PHASE (generator -> controller).
interface uart_baud_gen_if #(
  parameter int N   = 16,
  parameter int OVS = 16
);
  localparam int CW = $clog2(OVS);

  logic          EN;
  logic          INC_LOAD;
  logic [N-1:0]  INC_IN;
  logic          RX_RESYNC;
  logic          TICK_OVS;
  logic          TICK_TX;
  logic          RX_SAMPLE;
  logic [CW-1:0] RX_PHASE;

  modport master (
    output EN, INC_LOAD, INC_IN, RX_RESYNC,
    input  TICK_OVS, TICK_TX, RX_SAMPLE, RX_PHASE
  );

  modport slave (
    input  EN, INC_LOAD, INC_IN, RX_RESYNC,
    output TICK_OVS, TICK_TX, RX_SAMPLE, RX_PHASE
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Purpose : NCO baud-tick generator: oversample tick, TX bit tick, RX mid-bit sample strobe.
// Latency : strobes are registered; each is high the cycle after the edge whose carry produced it.
// Backpressure: none; strobes are unconditional one-cycle enables, nothing is held or queued.
// Ports   : CLK, RST (async, active high) plain; bus (slave) carries EN, INC_LOAD, INC_IN,
//           RX_RESYNC in and TICK_OVS, TICK_TX, RX_SAMPLE, RX_PHASE out.
module uart_baud_gen #(
  parameter int          N           = 16,
  parameter int          OVS         = 16,
  parameter int unsigned DEFAULT_INC = 1
) (
  input  logic           CLK,
  input  logic           RST,
  uart_baud_gen_if.slave bus
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(OVS / 2 - 1);
  localparam logic [N-1:0]  INC_RST = N'(DEFAULT_INC);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  inc_q, inc_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          tick_ovs_q, tick_ovs_d;
  logic          tick_tx_q, tick_tx_d;
  logic          rx_sample_q, rx_sample_d;
  logic [N:0]    sum;

  always_comb begin
    // Carry out of the N+1-bit sum is the oversample event.
    sum         = {1'b0, acc_q} + {1'b0, inc_q};
    state_d     = state_q;
    acc_d       = acc_q;
    inc_d       = inc_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    tick_ovs_d  = 1'b0;
    tick_tx_d   = 1'b0;
    rx_sample_d = 1'b0;

    // Increment may be reloaded in any state; this edge's addition still uses inc_q.
    if (bus.INC_LOAD) begin
      inc_d = bus.INC_IN;
    end

    case (state_q)
      IDLE: begin
        acc_d    = '0;
        tx_cnt_d = '0;
        rx_cnt_d = '0;
        if (bus.EN) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.EN) begin
          state_d  = IDLE;
          acc_d    = '0;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
        end else begin
          acc_d      = sum[N-1:0];
          tick_ovs_d = sum[N];
          if (sum[N]) begin
            tick_tx_d   = (tx_cnt_q == CNT_MAX);
            tx_cnt_d    = (tx_cnt_q == CNT_MAX) ? '0 : tx_cnt_q + CW'(1);
            rx_sample_d = (rx_cnt_q == CNT_MID);
            rx_cnt_d    = (rx_cnt_q == CNT_MAX) ? '0 : rx_cnt_q + CW'(1);
          end
          // Resync only restarts the RX bit phase; it overrides a coincident carry
          // so the first sample lands OVS/2 carries after the start-bit edge.
          if (bus.RX_RESYNC) begin
            rx_cnt_d    = '0;
            rx_sample_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      inc_q       <= INC_RST;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      tick_ovs_q  <= 1'b0;
      tick_tx_q   <= 1'b0;
      rx_sample_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      tick_ovs_q  <= tick_ovs_d;
      tick_tx_q   <= tick_tx_d;
      rx_sample_q <= rx_sample_d;
    end
  end

  assign bus.TICK_OVS  = tick_ovs_q;
  assign bus.TICK_TX   = tick_tx_q;
  assign bus.RX_SAMPLE = rx_sample_q;
  assign bus.RX_PHASE  = rx_cnt_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Purpose : scoreboard bench for uart_baud_gen (N=8, OVS=16, DEFAULT_INC=128).
// Latency : expected strobe cycles are pushed by the stimulus; a negedge monitor pops them.
// Backpressure: none; the monitor compares whenever a strobe appears.
module tb_uart_baud_gen;
  localparam int N   = 8;
  localparam int OVS = 16;

  logic CLK = 1'b0;
  logic RST;

  uart_baud_gen_if #(.N(N), .OVS(OVS)) bus ();

  uart_baud_gen #(.N(N), .OVS(OVS), .DEFAULT_INC(128)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // cyc = number of rising edges seen so far.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int c;
    int v;
  } lvl_t;

  int   exp_ovs[$];
  int   exp_tx[$];
  int   exp_rx[$];
  lvl_t lvl_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int obs_now();
    return int'({bus.TICK_OVS, bus.TICK_TX, bus.RX_SAMPLE, bus.RX_PHASE});
  endfunction

  // Output vector {TICK_OVS, TICK_TX, RX_SAMPLE, RX_PHASE[3:0]} as an int.
  function automatic int vec(input int o, input int t, input int r, input int ph);
    return (o << 6) | (t << 5) | (r << 4) | (ph & 15);
  endfunction

  task automatic push_lvl(input int c, input int v);
    lvl_t l;
    l.c = c;
    l.v = v;
    lvl_q.push_back(l);
  endtask

  // inc=128 run with EN sampled at edge s: carry every 2nd edge from s+2,
  // TX on every 16th carry, RX sample on the 8th and every 16th after.
  task automatic push128(input int s, input int nj);
    for (int j = 0; j < nj; j++) begin
      exp_ovs.push_back(s + 2 + 2 * j);
      if (j % 16 == 15) exp_tx.push_back(s + 2 + 2 * j);
      if (j % 16 == 7)  exp_rx.push_back(s + 2 + 2 * j);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic until_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic drain(input string nm);
    check_eq({"drain_", nm}, exp_ovs.size() + exp_tx.size() + exp_rx.size() + lvl_q.size(), 0);
    exp_ovs.delete();
    exp_tx.delete();
    exp_rx.delete();
    lvl_q.delete();
  endtask

  // Monitor: every strobe must match the head of its expected queue.
  always @(negedge CLK) begin
    int   e;
    lvl_t l;
    if (bus.TICK_OVS) begin
      if (exp_ovs.size() > 0) e = exp_ovs.pop_front(); else e = -1;
      check_eq("tick_ovs_cycle", cyc, e);
    end
    if (bus.TICK_TX) begin
      if (exp_tx.size() > 0) e = exp_tx.pop_front(); else e = -1;
      check_eq("tick_tx_cycle", cyc, e);
    end
    if (bus.RX_SAMPLE) begin
      if (exp_rx.size() > 0) e = exp_rx.pop_front(); else e = -1;
      check_eq("rx_sample_cycle", cyc, e);
    end
    while (lvl_q.size() > 0 && lvl_q[0].c < cyc) begin
      l = lvl_q.pop_front();
      check_eq("outputs_missed_cycle", cyc, l.c);
    end
    if (lvl_q.size() > 0 && lvl_q[0].c == cyc) begin
      l = lvl_q.pop_front();
      check_eq("outputs_vector", obs_now(), l.v);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time budget exceeded at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int s2;
    int s3;
    int t3[3];
    t3[0] = 86;
    t3[1] = 171;
    t3[2] = 256;

    // Reset held 3 cycles with EN=1: everything stays 0.
    RST           = 1'b1;
    bus.EN        = 1'b1;
    bus.INC_LOAD  = 1'b0;
    bus.INC_IN    = '0;
    bus.RX_RESYNC = 1'b0;
    #1 check_eq("reset_outputs", obs_now(), 0);
    for (int c = 1; c <= 3; c++) push_lvl(c, 0);
    until_cyc(3);
    RST = 1'b0;
    s = cyc + 1;

    // Default inc=128: tick every 2 cycles, TX every 16 ticks, RX at tick 8.
    push_lvl(s + 1, 0);
    push_lvl(s + 2, vec(1, 0, 0, 1));
    push_lvl(s + 16, vec(1, 0, 1, 8));
    push_lvl(s + 32, vec(1, 1, 0, 0));
    push128(s, 40);
    until_cyc(s + 80);
    bus.EN = 1'b0;
    step(2);
    drain("default_rate");

    // inc=3 loaded in IDLE: carries at accumulation 86,171,256 per 256 edges.
    bus.INC_LOAD = 1'b1;
    bus.INC_IN   = 8'd3;
    step(1);
    bus.INC_LOAD = 1'b0;
    bus.EN       = 1'b1;
    s = cyc + 1;
    push_lvl(s + 1, 0);
    push_lvl(s + 86, vec(1, 0, 0, 1));
    push_lvl(s + 768, vec(1, 0, 0, 9));
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 3; k++) exp_ovs.push_back(s + 256 * g + t3[k]);
    exp_rx.push_back(s + 683);
    until_cyc(s + 768);
    bus.EN = 1'b0;
    step(2);
    drain("fractional_inc");

    // Resync between ticks: RX realigns, TX keeps its reference timing.
    bus.INC_LOAD = 1'b1;
    bus.INC_IN   = 8'd128;
    step(1);
    bus.INC_LOAD = 1'b0;
    bus.EN       = 1'b1;
    s = cyc + 1;
    for (int j = 0; j < 32; j++) exp_ovs.push_back(s + 2 + 2 * j);
    exp_tx.push_back(s + 32);
    exp_tx.push_back(s + 64);
    exp_rx.push_back(s + 26);
    exp_rx.push_back(s + 58);
    push_lvl(s + 10, vec(1, 0, 0, 5));
    push_lvl(s + 11, 0);
    push_lvl(s + 12, vec(1, 0, 0, 1));
    push_lvl(s + 26, vec(1, 0, 1, 8));
    until_cyc(s + 10);
    bus.RX_RESYNC = 1'b1;
    step(1);
    bus.RX_RESYNC = 1'b0;
    until_cyc(s + 64);
    bus.EN = 1'b0;
    step(2);
    drain("resync_between");

    // Resync on the carry that would sample; then inc=0 freezes, reload resumes.
    bus.EN = 1'b1;
    s = cyc + 1;
    for (int j = 0; j < 16; j++) exp_ovs.push_back(s + 2 + 2 * j);
    for (int i = 0; i < 16; i++) exp_ovs.push_back(s + 52 + 2 * i);
    exp_tx.push_back(s + 32);
    exp_tx.push_back(s + 82);
    exp_rx.push_back(s + 32);
    exp_rx.push_back(s + 82);
    push_lvl(s + 14, vec(1, 0, 0, 7));
    push_lvl(s + 16, vec(1, 0, 0, 0));
    push_lvl(s + 32, vec(1, 1, 1, 8));
    push_lvl(s + 40, vec(0, 0, 0, 8));
    push_lvl(s + 52, vec(1, 0, 0, 9));
    until_cyc(s + 15);
    bus.RX_RESYNC = 1'b1;
    step(1);
    bus.RX_RESYNC = 1'b0;
    until_cyc(s + 32);
    bus.INC_LOAD = 1'b1;
    bus.INC_IN   = 8'd0;
    step(1);
    bus.INC_LOAD = 1'b0;
    until_cyc(s + 50);
    bus.INC_LOAD = 1'b1;
    bus.INC_IN   = 8'd128;
    step(1);
    bus.INC_LOAD = 1'b0;
    until_cyc(s + 82);
    bus.EN = 1'b0;
    step(2);
    drain("resync_carry_inc0");

    // Drop EN at tx_cnt=9, restart: timing must match a fresh run.
    bus.EN = 1'b1;
    s = cyc + 1;
    push128(s, 9);
    push_lvl(s + 18, vec(1, 0, 0, 9));
    push_lvl(s + 19, 0);
    until_cyc(s + 18);
    bus.EN = 1'b0;
    step(1);
    bus.EN = 1'b1;
    s2 = cyc + 1;
    push128(s2, 20);
    push_lvl(s2 + 32, vec(1, 1, 0, 0));
    push_lvl(s2 + 40, vec(1, 0, 0, 4));
    // Load inc=3 on the last carry edge so the reset must restore 128.
    until_cyc(s2 + 39);
    bus.INC_LOAD = 1'b1;
    bus.INC_IN   = 8'd3;
    step(1);
    bus.INC_LOAD = 1'b0;
    #2 RST = 1'b1;
    #1 check_eq("async_reset_outputs", obs_now(), 0);
    step(1);
    RST = 1'b0;
    s3 = cyc + 1;
    push128(s3, 8);
    push_lvl(s3 + 2, vec(1, 0, 0, 1));
    until_cyc(s3 + 16);
    bus.EN = 1'b0;
    step(2);
    drain("en_drop_and_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud-tick generator for the UART path. It uses a fractional phase accumulator (NCO) with a runtime-loadable increment. All outputs are single-cycle enable strobes in the CLK domain; it does not produce derived clocks. It provides an oversample tick, a free-running TX bit tick, and an RX mid-bit sample strobe that the RX front end can resync on a start-bit edge.

Parameters:
N, 16, accumulator width; tick rate = f_CLK * inc / 2^N
OVS, 16, oversample ratio (ticks per bit); even, >= 4
DEFAULT_INC, 1, increment value loaded at reset; 0 < DEFAULT_INC < 2^N
CW, clog2(OVS), width of oversample counters (derived, not overridden)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
EN  in  1  run enable; 0 = idle, counters cleared
INC_LOAD  in  1  load INC_IN into increment register
INC_IN  in  N  new increment value
RX_RESYNC  in  1  restart RX bit phase (start-bit edge detected)
TICK_OVS  out  1  oversample strobe, 1 cycle
TICK_TX  out  1  TX bit strobe, 1 cycle, every OVS oversample ticks
RX_SAMPLE  out  1  RX mid-bit sample strobe, 1 cycle
RX_PHASE  out  CW  current RX oversample index

Behaviour:
- RST (async): state=IDLE, acc=0, inc=DEFAULT_INC, tx_cnt=0, rx_cnt=0. TICK_OVS, TICK_TX, RX_SAMPLE and RX_PHASE are all 0.
- All strobes are registered. Each strobe is high for exactly the one cycle following the edge that generated it.
- FSM states:
  - IDLE: acc and counters held at 0, strobes 0. EN=1 sampled at edge k moves to RUN after edge k.
  - RUN: EN=0 sampled moves to IDLE on the same edge. At that edge acc, tx_cnt and rx_cnt clear, and strobes go to 0.
- Accumulation happens on every edge where state==RUN and EN==1: {carry,acc} <= acc + inc (N+1-bit sum, modulo 2^N).
  - TICK_OVS <= carry.
  - The first accumulation occurs at edge k+1.
- inc register:
  - INC_LOAD=1 at an edge sets inc <= INC_IN. This is allowed in either state.
  - The addition at that same edge uses the old inc.
  - acc is not cleared on load, so phase is continuous.
  - inc=0 is legal: acc stalls and no strobes are produced.
- tx_cnt (free-running, 0..OVS-1):
  - Advances on each carry; wraps OVS-1 -> 0.
  - TICK_TX <= carry && tx_cnt==OVS-1.
  - TICK_TX is never affected by RX_RESYNC.
- rx_cnt (0..OVS-1):
  - Advances on each carry; wraps OVS-1 -> 0.
  - RX_SAMPLE <= carry && rx_cnt==OVS/2-1.
  - RX_PHASE = rx_cnt.
- RX_RESYNC=1 in RUN sets rx_cnt <= 0. acc is untouched, so resync granularity is one oversample tick.
  - If a carry occurs at the same edge, resync wins: rx_cnt=0 and RX_SAMPLE=0.
  - The first RX_SAMPLE after resync follows the (OVS/2)-th subsequent carry. After that, RX_SAMPLE repeats every OVS carries.
  - RX_RESYNC in IDLE is ignored.
- EN=0 together with RX_RESYNC or INC_LOAD: idle clearing applies, and INC_LOAD still updates inc.
- RST mid-operation: immediate return to reset values, including inc=DEFAULT_INC.

Test Plan:
(N=8, OVS=16, DEFAULT_INC=128 unless noted)
1. Assert RST for 3 cycles with EN=1 -> all outputs 0, RX_PHASE=0 throughout; after release, state behaviour starts from IDLE.
2. Release RST, EN=1 sampled at edge 1 -> first TICK_OVS after edge 3, then every 2 cycles; first TICK_TX on the 16th TICK_OVS (after edge 33), then every 32 cycles; first RX_SAMPLE on the 8th TICK_OVS, then every 32 cycles.
3. INC_LOAD with INC_IN=3 while IDLE, then EN=1 -> TICK_OVS gaps of 86, 85, 85 cycles repeating; exactly 3 ticks per 256 accumulation edges; zero drift over 768 edges.
4. Running at inc=128, pulse RX_RESYNC between TICK_OVS strobes -> RX_PHASE=0 next cycle; RX_SAMPLE on the 8th TICK_OVS after resync, then every 16th; TICK_TX timing unchanged versus a no-resync reference run.
5. RX_RESYNC coincident with a carry -> TICK_OVS still pulses, rx_cnt=0, RX_SAMPLE=0 even when rx_cnt was 7; load INC_IN=0 mid-run -> no strobes and acc frozen; reload 128 -> ticks resume from the frozen phase.
6. Drop EN mid-bit (tx_cnt=9) -> all strobes 0 and counters 0 after the next edge; re-assert EN -> timing identical to scenario 2. Async RST pulse mid-run between edges -> outputs clear immediately and inc returns to 128.
